// File: rtl/dac_tx.sv
// Generic FIFO: power-of-two DEPTH ring buffer with synchronous flush.
// Latency: a push is visible at rd_dat on the following cycle. No bypass path.
// Backpressure: wr_rdy drops when full. A pop in the same cycle does not free the slot early.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_vld,
    output logic          wr_rdy,
    input  logic [W-1:0]  wr_dat,
    output logic          rd_vld,
    input  logic          rd_rdy,
    output logic [W-1:0]  rd_dat,
    output logic [LW-1:0] level
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr_fire, rd_fire;

    assign wr_rdy  = (level != LW'(DEPTH));
    assign rd_vld  = (level != '0);
    assign rd_dat  = mem[rd_ptr];
    assign wr_fire = wr_vld && wr_rdy;
    assign rd_fire = rd_rdy && rd_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
            if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(wr_fire) - LW'(rd_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= wr_dat;
    end
endmodule

// Parallel DAC driver: paces buffered samples out at clk/DIVISOR with a 50% latch clock.
// Latency: first sample reaches dac_val one cycle after priming; then one sample per tick.
// Backpressure: s_ready drops when the 4-entry FIFO is full; an empty FIFO at a tick flags underflow.
module dac_tx #(
    parameter int          DIVISOR  = 10,
    parameter logic [13:0] MIDSCALE = 14'h2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [13:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        clr_underflow,
    output logic [13:0] dac_val,
    output logic        dac_clk,
    output logic        underflow,
    output logic [2:0]  fifo_level
);
    localparam int CW = $clog2(DIVISOR);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          first;
    logic          tick, stop, pop_req, dac_clk_nxt;
    logic          head_vld;
    logic [13:0]   head_dat;

    fifo #(.W(14), .DEPTH(4), .LW(3)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .flush  (stop),
        .wr_vld (s_valid),
        .wr_rdy (s_ready),
        .wr_dat (s_data),
        .rd_vld (head_vld),
        .rd_rdy (pop_req),
        .rd_dat (head_dat),
        .level  (fifo_level)
    );

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = '0;
        tick        = 1'b0;
        stop        = 1'b0;
        pop_req     = 1'b0;
        dac_clk_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (enable && fifo_level >= 3'd2) state_nxt = RUN;
            end
            RUN: begin
                tick    = (cnt == CW'(DIVISOR - 1));
                stop    = tick && !enable;
                pop_req = first || (tick && enable);
                if (stop) begin
                    state_nxt = IDLE;
                end else begin
                    dac_clk_nxt = (cnt >= CW'(DIVISOR / 2));
                    // The load cycle holds the phase at 0 so the first period is a full DIVISOR long.
                    if (!first && !tick) cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            first     <= 1'b0;
            dac_clk   <= 1'b0;
            dac_val   <= MIDSCALE;
            underflow <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            first   <= (state == IDLE) && (state_nxt == RUN);
            dac_clk <= dac_clk_nxt;
            if (state == IDLE || stop)      dac_val <= MIDSCALE;
            else if (pop_req && head_vld)   dac_val <= head_dat;
            if (pop_req && !head_vld)       underflow <= 1'b1;
            else if (clr_underflow)         underflow <= 1'b0;
        end
    end
endmodule
